// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions.
// Fetch FSM encodings and common constants.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    F_REQ     = 2'd0,
    F_WAIT    = 2'd1,
    F_DISCARD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus.
// One request outstanding at a time; response follows grant.
interface fetch_stage_if #(
  parameter int XLEN = 32
);
  logic            req;
  logic [XLEN-1:0] addr;
  logic            gnt;
  logic            rvalid;
  logic [31:0]     rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry holding buffer for a fetched instruction.
// Catches a response while decode is stalled.
module fetch_hold_buf #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_clr,
  input  logic            i_load,
  input  logic            i_drain,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_valid,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_pc
);

  logic            r_valid;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_pc;

  // clear wins over load; load and drain never coincide
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: fetch PC, imem FSM,
// holding buffer and IF/ID pipeline register.
module fetch_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  fetch_stage_if.master   imem,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);

  import riscv_pkg::*;

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic [XLEN-1:0] r_pcf;
  logic [XLEN-1:0] r_pc_inflight;
  logic [XLEN-1:0] w_tgt;
  logic            w_req;
  logic            w_hs;
  logic            w_resp;
  logic            w_deliver;
  logic            w_buf_valid;
  logic            w_buf_load;
  logic            w_buf_drain;
  logic            w_buf_clr;
  logic [31:0]     w_buf_instr;
  logic [XLEN-1:0] w_buf_pc;

  assign w_tgt = PCTargetE & ~XLEN'(3);

  assign w_req = (r_state == F_REQ) & ~w_buf_valid
               & ~StallF & ~PCSrcE & ~rst;
  assign imem.req  = w_req;
  assign imem.addr = r_pcf;

  assign w_hs      = w_req & imem.gnt;
  assign w_resp    = imem.rvalid & (r_state == F_WAIT) & ~rst;
  assign w_deliver = w_resp & ~PCSrcE;

  assign w_buf_clr   = PCSrcE | FlushD;
  assign w_buf_load  = w_deliver & StallD & ~FlushD;
  assign w_buf_drain = w_buf_valid & ~StallD;

  fetch_hold_buf #(
    .XLEN (XLEN)
  ) u_hold_buf (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_buf_clr),
    .i_load  (w_buf_load),
    .i_drain (w_buf_drain),
    .i_instr (imem.rdata),
    .i_pc    (r_pc_inflight),
    .o_valid (w_buf_valid),
    .o_instr (w_buf_instr),
    .o_pc    (w_buf_pc)
  );

  // next state: track outstanding request and its staleness
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      F_REQ: begin
        if (w_hs) w_state_nxt = F_WAIT;
      end
      F_WAIT: begin
        if (imem.rvalid)  w_state_nxt = F_REQ;
        else if (PCSrcE)  w_state_nxt = F_DISCARD;
      end
      F_DISCARD: begin
        if (imem.rvalid) w_state_nxt = F_REQ;
      end
      default: w_state_nxt = F_REQ;
    endcase
  end

  // fetch FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= F_REQ;
    else     r_state <= w_state_nxt;
  end

  // fetch PC: redirect beats sequential advance
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pcf         <= RESET_PC;
      r_pc_inflight <= '0;
    end else if (PCSrcE) begin
      r_pcf <= w_tgt;
    end else if (w_hs) begin
      r_pc_inflight <= r_pcf;
      r_pcf         <= r_pcf + XLEN'(4);
    end
  end

  // IF/ID register: flush > stall > buffer > direct > bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (FlushD) begin
      InstrD <= NOP_INSTR;
      ValidD <= 1'b0;
    end else if (!StallD) begin
      if (w_buf_valid && !PCSrcE) begin
        InstrD   <= w_buf_instr;
        PCD      <= w_buf_pc;
        PCPlus4D <= w_buf_pc + XLEN'(4);
        ValidD   <= 1'b1;
      end else if (w_deliver) begin
        InstrD   <= imem.rdata;
        PCD      <= r_pc_inflight;
        PCPlus4D <= r_pc_inflight + XLEN'(4);
        ValidD   <= 1'b1;
      end else begin
        InstrD <= NOP_INSTR;
        ValidD <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
// Second instance checks PC wrap from 0xFFFF_FFFC.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;
  logic [31:0] InstrD2, PCD2, PCPlus4D2;
  logic        ValidD2;

  int total = 0;
  int bad   = 0;

  fetch_stage_if #(.XLEN(32)) m ();
  fetch_stage_if #(.XLEN(32)) m2 ();

  always #5 clk = ~clk;

  fetch_stage #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .imem      (m),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD)
  );

  fetch_stage #(
    .XLEN     (32),
    .RESET_PC (32'hFFFF_FFFC)
  ) u_dut2 (
    .clk       (clk),
    .rst       (rst),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .imem      (m2),
    .InstrD    (InstrD2),
    .PCD       (PCD2),
    .PCPlus4D  (PCPlus4D2),
    .ValidD    (ValidD2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    StallF = 1'b0; StallD = 1'b0;
    FlushD = 1'b0; PCSrcE = 1'b0;
    PCTargetE = '0;
    m.gnt = 1'b0; m.rvalid = 1'b0; m.rdata = '0;
    m2.gnt = 1'b0; m2.rvalid = 1'b0; m2.rdata = '0;
    tick();
    tick();

    chk("rst_instr", InstrD, 32'h13);
    chk("rst_valid", {31'd0, ValidD}, 32'd0);
    chk("rst_pcd", PCD, 32'd0);
    chk("rst_pc4", PCPlus4D, 32'd0);
    chk("rst_req", {31'd0, m.req}, 32'd0);
    chk("rst_addr2", m2.addr, 32'hFFFF_FFFC);

    // t0: first request in first cycle with rst low
    rst = 1'b0;
    m.gnt = 1'b1; m2.gnt = 1'b1;
    #1;
    chk("t0_req", {31'd0, m.req}, 32'd1);
    chk("t0_addr", m.addr, 32'h0);
    chk("t0_req2", {31'd0, m2.req}, 32'd1);
    tick();

    // t1: response
    m.gnt = 1'b0; m.rvalid = 1'b1; m.rdata = 32'h0050_0093;
    m2.gnt = 1'b0; m2.rvalid = 1'b1; m2.rdata = 32'h0000_0113;
    #1;
    chk("t1_req", {31'd0, m.req}, 32'd0);
    chk("wrap_addr2", m2.addr, 32'h0);
    tick();

    // t2: delivered; next request at 0x4
    m.rvalid = 1'b0; m2.rvalid = 1'b0;
    chk("d1_instr", InstrD, 32'h0050_0093);
    chk("d1_pcd", PCD, 32'h0);
    chk("d1_pc4", PCPlus4D, 32'h4);
    chk("d1_valid", {31'd0, ValidD}, 32'd1);
    chk("wrap_pcd2", PCD2, 32'hFFFF_FFFC);
    chk("wrap_pc42", PCPlus4D2, 32'h0);
    m.gnt = 1'b1;
    #1;
    chk("t2_req", {31'd0, m.req}, 32'd1);
    chk("t2_addr", m.addr, 32'h4);
    tick();

    // t3: response while StallD -> buffered
    m.gnt = 1'b0; m.rvalid = 1'b1; m.rdata = 32'h00A0_0113;
    StallD = 1'b1;
    tick();
    m.rvalid = 1'b0;
    #1;
    chk("stl_req_a", {31'd0, m.req}, 32'd0);
    chk("stl_instr_a", InstrD, 32'h13);
    tick();
    chk("stl_req_b", {31'd0, m.req}, 32'd0);
    chk("stl_valid_b", {31'd0, ValidD}, 32'd0);
    StallD = 1'b0;
    #1;
    chk("stl_req_c", {31'd0, m.req}, 32'd0);
    tick();

    // buffered instruction reaches IF/ID
    chk("buf_instr", InstrD, 32'h00A0_0113);
    chk("buf_pcd", PCD, 32'h4);
    chk("buf_pc4", PCPlus4D, 32'h8);
    chk("buf_valid", {31'd0, ValidD}, 32'd1);
    chk("buf_req", {31'd0, m.req}, 32'd1);
    chk("buf_addr", m.addr, 32'h8);
    m.gnt = 1'b1;
    tick();

    // redirect while WAIT; low target bits ignored
    m.gnt = 1'b0;
    PCSrcE = 1'b1; PCTargetE = 32'h0000_0103;
    #1;
    chk("rdw_req", {31'd0, m.req}, 32'd0);
    tick();
    PCSrcE = 1'b0;
    m.rvalid = 1'b1; m.rdata = 32'hDEAD_BEEF;
    #1;
    chk("disc_req", {31'd0, m.req}, 32'd0);
    chk("disc_addr", m.addr, 32'h100);
    tick();
    m.rvalid = 1'b0;
    chk("disc_valid", {31'd0, ValidD}, 32'd0);
    chk("disc_instr", InstrD, 32'h13);
    chk("tgt_req", {31'd0, m.req}, 32'd1);
    chk("tgt_addr", m.addr, 32'h100);
    m.gnt = 1'b1;
    tick();
    m.gnt = 1'b0; m.rvalid = 1'b1; m.rdata = 32'h0010_0193;
    tick();
    m.rvalid = 1'b0;
    chk("tgt_instr", InstrD, 32'h0010_0193);
    chk("tgt_pcd", PCD, 32'h100);
    chk("tgt_valid", {31'd0, ValidD}, 32'd1);

    // redirect and response in the same cycle
    m.gnt = 1'b1;
    tick();
    m.gnt = 1'b0; m.rvalid = 1'b1; m.rdata = 32'h1111_1111;
    PCSrcE = 1'b1; PCTargetE = 32'h200;
    tick();
    PCSrcE = 1'b0; m.rvalid = 1'b0;
    #1;
    chk("same_valid", {31'd0, ValidD}, 32'd0);
    chk("same_instr", InstrD, 32'h13);
    chk("same_req", {31'd0, m.req}, 32'd1);
    chk("same_addr", m.addr, 32'h200);
    m.gnt = 1'b1;
    tick();

    // buffer a response, then FlushD with StallD
    m.gnt = 1'b0; m.rvalid = 1'b1; m.rdata = 32'h0020_0213;
    StallD = 1'b1;
    tick();
    m.rvalid = 1'b0;
    FlushD = 1'b1;
    tick();
    chk("fl_instr", InstrD, 32'h13);
    chk("fl_valid", {31'd0, ValidD}, 32'd0);
    StallD = 1'b0; FlushD = 1'b0;
    #1;
    chk("fl_req", {31'd0, m.req}, 32'd1);
    chk("fl_addr", m.addr, 32'h204);
    m.gnt = 1'b1;
    tick();
    chk("fl_instr2", InstrD, 32'h13);
    chk("fl_pcd", PCD, 32'h100);

    // deliver, then reset mid-WAIT
    m.gnt = 1'b0; m.rvalid = 1'b1; m.rdata = 32'h0030_0293;
    tick();
    m.rvalid = 1'b0;
    chk("pr_instr", InstrD, 32'h0030_0293);
    chk("pr_pcd", PCD, 32'h204);
    chk("pr_pc4", PCPlus4D, 32'h208);
    m.gnt = 1'b1;
    tick();
    m.gnt = 1'b0;
    rst = 1'b1;
    #1;
    chk("mr_req", {31'd0, m.req}, 32'd0);
    tick();
    chk("mr_instr", InstrD, 32'h13);
    chk("mr_valid", {31'd0, ValidD}, 32'd0);
    chk("mr_pcd", PCD, 32'h0);
    chk("mr_pc4", PCPlus4D, 32'h0);
    chk("mr_addr", m.addr, 32'h0);

    // late response after reset ignored
    rst = 1'b0;
    m.rvalid = 1'b1; m.rdata = 32'h0BAD_0BAD;
    #1;
    chk("late_req", {31'd0, m.req}, 32'd1);
    tick();
    m.rvalid = 1'b0;
    chk("late_valid", {31'd0, ValidD}, 32'd0);
    chk("late_instr", InstrD, 32'h13);

    // StallF suppresses request and holds PC
    StallF = 1'b1;
    m.gnt = 1'b1;
    #1;
    chk("sf_req", {31'd0, m.req}, 32'd0);
    tick();
    chk("sf_addr", m.addr, 32'h0);
    StallF = 1'b0;
    m.gnt = 1'b0;
    #1;
    chk("sf_req2", {31'd0, m.req}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
